// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and mode constants for the bit-serial add/sub block.
// Revision : 1.0  initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic c_mode_add = 1'b0;
    localparam logic c_mode_sub = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_if
// Purpose  : Host-side request/result bundle of the bit-serial add/sub block.
// Revision : 1.0  initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             all_prop;

    modport master (
        output start, sub, a, b, cin,
        input  ready, busy, valid, sum, cout, all_prop
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, busy, valid, sum, cout, all_prop
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : fa_cell
// Purpose  : One-bit full adder exposing sum, propagate and carry-out.
// Revision : 1.0  initial release
// ============================================================================
module fa_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic c,
    output logic      sum,
    output logic      propagate,
    output logic      carry
);
    assign propagate = a ^ b;
    assign sum       = propagate ^ c;
    assign carry     = (a & b) | (propagate & c);
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial add/subtract sequencer, one bit per clock, LSB first.
//            Optional SERIAL_ADD_EARLY_DONE_EN stops add runs once the rest
//            of the operands and the carry are zero.
// Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int                  c_idx_w    = $clog2(WIDTH);
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_idx_w-1:0] r_idx;
    logic               r_carry;
    logic               r_prop;
    logic               r_ready;
    logic               r_busy;
    logic               r_valid;
    logic               r_cout;
    logic               r_all_prop;

    logic w_s;
    logic w_p;
    logic w_c;
    logic w_last;
    logic w_early;

    fa_cell u_fa (
        .a         (r_a[r_idx]),
        .b         (r_b[r_idx]),
        .c         (r_carry),
        .sum       (w_s),
        .propagate (w_p),
        .carry     (w_c)
    );

    assign w_last = (r_idx == c_last_idx);

`ifdef SERIAL_ADD_EARLY_DONE_EN
    logic               r_add_mode;
    logic [c_idx_w:0]   w_shamt;
    logic [WIDTH-1:0]   w_upper;

    // Nothing above the current bit can change the result once these are zero.
    assign w_shamt = {1'b0, r_idx} + (c_idx_w + 1)'(1);
    assign w_upper = (r_a | r_b) >> w_shamt;
    assign w_early = r_add_mode && (w_upper == '0) && !w_c;
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_prop     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_cout     <= 1'b0;
            r_all_prop <= 1'b0;
`ifdef SERIAL_ADD_EARLY_DONE_EN
            r_add_mode <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= (bus.sub == c_mode_sub) ? ~bus.b : bus.b;
                        r_carry <= (bus.sub == c_mode_sub) ? ~bus.cin : bus.cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                        r_prop  <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
`ifdef SERIAL_ADD_EARLY_DONE_EN
                        r_add_mode <= (bus.sub == c_mode_add);
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= w_s;
                    r_carry      <= w_c;
                    r_prop       <= r_prop & w_p;
                    if (w_last || w_early) begin
                        r_state    <= DONE;
                        r_valid    <= 1'b1;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cout     <= w_c;
                        // An early stop leaves zero bits above, so no group propagate.
                        r_all_prop <= r_prop & w_p & w_last;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.valid    = r_valid;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.all_prop = r_all_prop;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer that time-multiplexes a single full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake, steps the cell through every bit position while keeping the running carry in a flop, and presents sum, carry-out and a group-propagate flag with a one-cycle valid pulse. It sits between a register-file/host interface and the one-bit adder datapath, as an area-minimal alternative to the parallel carry-skip adder.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- sub  input  1  0: a+b+cin, 1: a−b−cin (sampled with start)
- a  input  WIDTH  operand A (sampled with start)
- b  input  WIDTH  operand B (sampled with start)
- cin  input  1  carry/borrow in (sampled with start)
- ready  output  1  high in IDLE or DONE
- busy  output  1  high in RUN
- valid  output  1  one-cycle pulse, result available
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry (sub: 1 = no borrow)
- all_prop  output  1  AND of per-bit propagate (a^b') over all bits

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE, start=1: latch a, b' = sub ? ~b : b, carry = sub ? ~cin : cin; clear sum register, bit index to 0, propagate accumulator to 1; → RUN.
- IDLE, start=0: stay. DONE, start=0: → IDLE.
- RUN, each cycle: FA cell computes s, p, c on (a[idx], b'[idx], carry); sum[idx] ← s; carry ← c; prop_acc ← prop_acc & p; idx ← idx+1. At idx=WIDTH−1 → DONE, cout ← c, all_prop ← prop_acc & p.
- start in RUN is ignored (not queued); operands on a/b/sub/cin may change freely after acceptance.
- Index counter width $clog2(WIDTH); never wraps beyond WIDTH−1.
- Sub mode: result is two's complement a − b − cin mod 2^WIDTH.

## Timing
- Reset values: ready=1, busy=0, valid=0, sum=0, cout=0, all_prop=0; state IDLE.
- start sampled at edge E0 → busy high after E0; bits processed at edges E1..EW; valid high for the cycle after EW (latency WIDTH cycles edge-to-valid).
- sum, cout, all_prop update on EW and are stable while valid=1 and afterwards until the next accepted start.
- start held high in DONE is accepted immediately: back-to-back throughput one result per WIDTH+1 cycles.
- rst_n low mid-RUN: immediate return to IDLE, all outputs to reset values, partial result discarded; no valid pulse.

## Configuration
- SERIAL_ADD_EARLY_DONE_EN defined: in RUN with sub=0, if a[WIDTH−1:idx+1] and b'[WIDTH−1:idx+1] are all zero and c=0, go to DONE after the current bit (remaining sum bits stay 0, cout=0, all_prop=0). Latency becomes (index of highest nonzero operand bit, or carry bit)+1, minimum 1. Sub mode always runs full WIDTH.
- Undefined: fixed WIDTH-cycle latency for all operands.

## Structure
- Package serial_add_pkg: state enum (IDLE, RUN, DONE), SUB/ADD mode constants.
- One sub-module: fa_cell (combinational, inputs a, b, c; outputs sum, propagate, carry), instantiated once; controller owns all flops.

## Test plan
- WIDTH=8, add 8'h3C+8'h45, cin=0 → valid 8 cycles after start, sum=8'h81, cout=0, all_prop=0.
- Add 8'hFF+8'h00, cin=1 → sum=8'h00, cout=1, all_prop=1.
- Sub 8'h10−8'h01, cin=0 → sum=8'h0F, cout=1; sub 8'h01−8'h02 → sum=8'hFF, cout=0.
- start held high continuously → results every 9 cycles, busy low only in DONE cycle; start pulses during RUN produce no extra valid.
- rst_n asserted at bit 4 of a run → outputs all zero asynchronously, no valid; next start completes normally.
- With SERIAL_ADD_EARLY_DONE_EN: add 8'h03+8'h01 → valid after 3 cycles, sum=8'h04, cout=0; without macro same operands → 8 cycles, same result.
